// File: rtl/vga_fetch_arb.sv
// vga_fetch_arb: arbitrates one pixel memory between display line bursts
// (strict priority) and host writes, filling a double-banked line buffer.
module vga_fetch_arb #(
    parameter int WORDS_PER_LINE = 80,
    parameter int V_ACTIVE       = 480,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int LB_AW          = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              next_line,
    input  logic              next_frame,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              busy,
    output logic              underrun
);
    localparam int CW = $clog2(V_ACTIVE + 1);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t            state_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LB_AW-1:0]  word_q, pidx_q, lb_addr_q;
    logic [DATA_W-1:0] lb_data_q;
    logic              pend_q, lb_we_q, lb_bank_q, busy_q, underrun_q;
    logic              overrun, last, adv, start;

    // An abandoned burst still consumes its line; a frame pulse then overrides.
    always_comb begin
        overrun   = next_line && busy_q;
        last      = state_q == FETCH && word_q == LB_AW'(WORDS_PER_LINE - 1);
        adv       = state_q == FETCH && (last || overrun);
        cnt_d     = next_frame ? '0 : adv ? cnt_q + CW'(1) : cnt_q;
        base_d    = next_frame ? '0 : adv ? base_q + ADDR_W'(WORDS_PER_LINE) : base_q;
        start     = next_line && cnt_d < CW'(V_ACTIVE);
        host_gnt  = rst_n && host_req && state_q == IDLE && !start;
        mem_we    = host_gnt;
        mem_addr  = state_q == FETCH ? base_q + ADDR_W'(word_q) : host_gnt ? host_addr : '0;
        mem_wdata = host_gnt ? host_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            word_q     <= '0;
            pidx_q     <= '0;
            pend_q     <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_bank_q  <= 1'b0;
            lb_addr_q  <= '0;
            lb_data_q  <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            pend_q  <= state_q == FETCH && !overrun;
            pidx_q  <= word_q;
            lb_we_q <= pend_q && !overrun;
            if (pend_q && !overrun) begin
                lb_addr_q <= pidx_q;
                lb_data_q <= mem_rdata;
            end
            if (overrun) underrun_q <= 1'b1;
            if (start) begin
                state_q   <= FETCH;
                word_q    <= '0;
                lb_bank_q <= !lb_bank_q;
                busy_q    <= 1'b1;
            end else if (overrun || state_q == DRAIN) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (state_q == FETCH) begin
                word_q <= word_q + LB_AW'(1);
                if (last) state_q <= DRAIN;
            end
        end
    end

    assign lb_we    = lb_we_q;
    assign lb_bank  = lb_bank_q;
    assign lb_addr  = lb_addr_q;
    assign lb_data  = lb_data_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_vga_fetch_arb.sv
// tb_vga_fetch_arb: directed bench for vga_fetch_arb with a memory model
// that returns addr[7:0] one cycle after the address.
module tb_vga_fetch_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        next_line = 1'b0, next_frame = 1'b0, host_req = 1'b0;
    logic [15:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        host_gnt, mem_we, lb_we, lb_bank, busy, underrun;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata = '0, lb_data;
    logic [6:0]  lb_addr;
    int          checks = 0, errors = 0, first;

    vga_fetch_arb dut (
        .clk(clk), .rst_n(rst_n), .next_line(next_line), .next_frame(next_frame),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_gnt(host_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we),
        .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_data(lb_data),
        .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= mem_addr[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse next_line and follow the whole burst cycle by cycle.
    task automatic burst(input int base, input logic bank);
        next_line = 1'b1;
        step();
        next_line = 1'b0;
        chk("burst_bank", lb_bank, bank);
        for (int j = 0; j <= 82; j++) begin
            if (j > 0) step();
            chk("burst_busy", busy, j <= 80);
            if (j <= 79) chk("burst_mem_addr", mem_addr, base + j);
            chk("burst_lb_we", lb_we, j >= 2 && j <= 81);
            if (j >= 2 && j <= 81) begin
                chk("burst_lb_addr", lb_addr, j - 2);
                chk("burst_lb_data", lb_data, (base + j - 2) & 255);
            end
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_lb_bank", lb_bank, 0);
        chk("rst_lb_addr", lb_addr, 0);
        chk("rst_lb_data", lb_data, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_gnt", host_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        step();
        rst_n = 1'b1;
        step();
        next_frame = 1'b1;
        step();
        next_frame = 1'b0;
        step();
        burst(0, 1'b1);
        repeat (700) step();
        burst(80, 1'b0);

        // host held off by a burst
        next_line = 1'b1;
        step();
        next_line = 1'b0;
        for (int j = 1; j <= 81; j++) begin
            step();
            if (j == 1) begin
                host_req = 1'b1; host_addr = 16'h1234; host_data = 8'hA5;
            end
            #1;
            chk("hold_gnt", host_gnt, j == 81);
            if (j == 81) begin
                chk("hold_mem_we", mem_we, 1);
                chk("hold_mem_addr", mem_addr, 16'h1234);
                chk("hold_mem_wdata", mem_wdata, 8'hA5);
            end
        end
        host_req = 1'b0;
        #1;
        chk("hold_gnt_drop", host_gnt, 0);
        chk("hold_mem_addr_idle", mem_addr, 0);

        // host request coincident with a burst start
        step();
        host_req = 1'b1; host_addr = 16'h0042; host_data = 8'h3C; next_line = 1'b1;
        #1;
        chk("coinc_gnt", host_gnt, 0);
        chk("coinc_mem_we", mem_we, 0);
        step();
        next_line = 1'b0;
        chk("coinc_busy", busy, 1);
        first = 0;
        for (int j = 1; j <= 120 && first == 0; j++) begin
            step();
            if (host_gnt) begin
                first = j;
                chk("coinc_mem_addr", mem_addr, 16'h0042);
                chk("coinc_mem_wdata", mem_wdata, 8'h3C);
                host_req = 1'b0;
            end
        end
        chk("coinc_first_gnt", first, 81);
        host_req = 1'b0;

        // overrun: second pulse 40 cycles into the line-4 burst
        repeat (3) step();
        chk("ovr_pre_underrun", underrun, 0);
        next_line = 1'b1;
        step();
        next_line = 1'b0;
        chk("ovr_bank1", lb_bank, 1);
        chk("ovr_addr1", mem_addr, 320);
        repeat (39) step();
        next_line = 1'b1;
        step();
        next_line = 1'b0;
        chk("ovr_underrun", underrun, 1);
        chk("ovr_busy", busy, 1);
        chk("ovr_bank2", lb_bank, 0);
        chk("ovr_addr_new", mem_addr, 400);
        chk("ovr_lb_we_drop", lb_we, 0);
        step();
        chk("ovr_addr_next", mem_addr, 401);
        chk("ovr_lb_we_next", lb_we, 0);
        repeat (85) step();
        chk("ovr_busy_end", busy, 0);
        chk("ovr_sticky", underrun, 1);

        // full frame: 480 bursts, the 481st pulse ignored
        next_frame = 1'b1; next_line = 1'b1;
        step();
        next_frame = 1'b0; next_line = 1'b0;
        chk("frm_addr0", mem_addr, 0);
        chk("frm_busy0", busy, 1);
        chk("frm_bank0", lb_bank, 1);
        for (int i = 2; i <= 480; i++) begin
            repeat (85) step();
            next_line = 1'b1;
            step();
            next_line = 1'b0;
            chk("frm_line_addr", mem_addr, (i - 1) * 80);
        end
        repeat (85) step();
        next_line = 1'b1;
        step();
        next_line = 1'b0;
        chk("frm_481_busy", busy, 0);
        chk("frm_481_addr", mem_addr, 0);
        chk("frm_481_bank", lb_bank, 0);
        step();
        chk("frm_481_busy2", busy, 0);
        chk("frm_481_lb_we", lb_we, 0);

        // reset asserted mid-burst
        next_frame = 1'b1; next_line = 1'b1;
        step();
        next_frame = 1'b0; next_line = 1'b0;
        chk("mid_addr0", mem_addr, 0);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_lb_we", lb_we, 0);
        chk("mid_bank", lb_bank, 0);
        chk("mid_underrun", underrun, 0);
        chk("mid_mem_addr", mem_addr, 0);
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("post_rst_lb_we", lb_we, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
